// File: rtl/posterior_sink.sv
// posterior_sink: captures bursts of signed posterior samples into a pair of
// ping-pong banks, tracks the per-frame argmax/max on the fly and presents the
// oldest complete frame to a reader that can index into it and release it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   dv_in, din        burst valid and signed sample (one sample per cycle)
//   frm_rdy           a complete frame is presented
//   frm_argmax/maxval index and value of the presented frame's largest sample
//   rd_addr, rd_data  registered read port into the presented frame
//   frm_ack           release the presented frame (ignored when frm_rdy=0)
//   err_short/long/ovf one-cycle pulses: truncated burst, surplus samples,
//                     burst arrived with both banks full
//   frm_cnt           frames accepted, wraps at 2^16
module posterior_sink #(
    parameter int OBIT = 11,
    parameter int IDIM = 42,
    parameter int AW   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dv_in,
    input  logic [OBIT-1:0] din,
    output logic            frm_rdy,
    output logic [AW-1:0]   frm_argmax,
    output logic [OBIT-1:0] frm_maxval,
    input  logic [AW-1:0]   rd_addr,
    output logic [OBIT-1:0] rd_data,
    input  logic            frm_ack,
    output logic            err_short,
    output logic            err_long,
    output logic            err_ovf,
    output logic [15:0]     frm_cnt
);
    localparam logic [AW-1:0] LAST_IDX = AW'(IDIM - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(IDIM);

    typedef enum logic [1:0] {IDLE, CAPT, DROP} state_t;
    state_t state, state_n;

    logic [AW-1:0]   idx;
    logic [1:0]      full, full_n;
    logic            wr_bank, pres_bank, pres_n;
    logic            armed, surplus, surplus_n;
    logic [OBIT-1:0] sample, run_max, new_max;
    logic [AW-1:0]   run_arg, new_arg;
    logic            take, wr_en, done, ack_ok;
    logic            e_short, e_long, e_ovf;

    logic [OBIT-1:0] mem      [2][IDIM];
    logic [OBIT-1:0] bank_max [2];
    logic [AW-1:0]   bank_arg [2];

    // Negative samples are clamped to 0; index 0 always seeds the running max,
    // strict '>' keeps the lowest index on ties.
    always_comb begin
        sample  = din[OBIT-1] ? '0 : din;
        take    = (idx == '0) || (sample > run_max);
        new_max = take ? sample : run_max;
        new_arg = take ? idx : run_arg;
    end

    always_comb begin
        state_n   = state;
        surplus_n = surplus;
        wr_en     = 1'b0;
        e_short   = 1'b0;
        e_long    = 1'b0;
        e_ovf     = 1'b0;
        case (state)
            IDLE: begin
                if (dv_in) begin
                    if (!armed) begin
                        // dv_in was already high out of reset: skip this burst
                        state_n = DROP;
                    end else if (full[wr_bank]) begin
                        // banks fill in order, so a full write bank means both are full
                        state_n   = DROP;
                        surplus_n = 1'b0;
                        e_ovf     = 1'b1;
                    end else begin
                        state_n = CAPT;
                        wr_en   = 1'b1;
                    end
                end
            end
            CAPT: begin
                if (dv_in) begin
                    wr_en = 1'b1;
                end else begin
                    state_n = IDLE;
                    e_short = 1'b1;
                end
            end
            DROP: begin
                if (!dv_in) begin
                    state_n   = IDLE;
                    surplus_n = 1'b0;
                end else if (surplus) begin
                    e_long    = 1'b1;
                    surplus_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        done = wr_en && (idx == LAST_IDX);
        // After completion sit in DROP: it exits on the next dv_in=0 cycle and
        // flags the first surplus sample if the burst keeps going.
        if (done) begin
            state_n   = DROP;
            surplus_n = 1'b1;
        end
    end

    // Frames are consumed in the order they were written, so presentation
    // simply alternates on every accepted ack.
    always_comb begin
        ack_ok = frm_ack && full[pres_bank];
        full_n = full;
        if (ack_ok) full_n[pres_bank] = 1'b0;
        if (done)   full_n[wr_bank]   = 1'b1;
        pres_n = ack_ok ? ~pres_bank : pres_bank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            full       <= '0;
            wr_bank    <= 1'b0;
            pres_bank  <= 1'b0;
            armed      <= 1'b0;
            surplus    <= 1'b0;
            frm_rdy    <= 1'b0;
            frm_argmax <= '0;
            frm_maxval <= '0;
            rd_data    <= '0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_ovf    <= 1'b0;
            frm_cnt    <= '0;
        end else begin
            state     <= state_n;
            idx       <= (wr_en && !done) ? idx + 1'b1 : '0;
            full      <= full_n;
            wr_bank   <= done ? ~wr_bank : wr_bank;
            pres_bank <= pres_n;
            armed     <= armed | ~dv_in;
            surplus   <= surplus_n;
            err_short <= e_short;
            err_long  <= e_long;
            err_ovf   <= e_ovf;
            if (done) frm_cnt <= frm_cnt + 16'd1;
            frm_rdy <= full_n[pres_n];
            if (full_n[pres_n]) begin
                // a frame completing straight into the presented slot has its
                // results only on the running-max path this cycle
                if (done && (pres_n == wr_bank)) begin
                    frm_argmax <= new_arg;
                    frm_maxval <= new_max;
                end else begin
                    frm_argmax <= bank_arg[pres_n];
                    frm_maxval <= bank_max[pres_n];
                end
            end
            rd_data <= ({1'b0, rd_addr} < DEPTH) ? mem[pres_bank][rd_addr] : '0;
        end
    end

    // Sample storage and per-bank results carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][idx] <= sample;
            run_max           <= new_max;
            run_arg           <= new_arg;
        end
        if (done) begin
            bank_max[wr_bank] <= new_max;
            bank_arg[wr_bank] <= new_arg;
        end
    end
endmodule

// File: tb/tb_posterior_sink.sv
module tb_posterior_sink;
    localparam int OBIT = 11;
    localparam int IDIM = 42;
    localparam int AW   = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dv_in = 1'b0;
    logic [OBIT-1:0] din = '0;
    logic            frm_rdy;
    logic [AW-1:0]   frm_argmax;
    logic [OBIT-1:0] frm_maxval;
    logic [AW-1:0]   rd_addr = '0;
    logic [OBIT-1:0] rd_data;
    logic            frm_ack = 1'b0;
    logic            err_short, err_long, err_ovf;
    logic [15:0]     frm_cnt;

    posterior_sink #(.OBIT(OBIT), .IDIM(IDIM), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .dv_in(dv_in), .din(din),
        .frm_rdy(frm_rdy), .frm_argmax(frm_argmax), .frm_maxval(frm_maxval),
        .rd_addr(rd_addr), .rd_data(rd_data), .frm_ack(frm_ack),
        .err_short(err_short), .err_long(err_long), .err_ovf(err_ovf),
        .frm_cnt(frm_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus samples as plain signed integers
    int stim [64];

    // reference model: FIFO of up to two complete frames (clamped samples)
    int mstore [2][IDIM];
    int mhead = 0, mcount = 0, mcnt = 0, m_am = 0, m_mv = 0;

    // observations of one burst
    int              obs_short, obs_long, obs_ovf, obs_long_at;
    logic            obs_rdy;
    logic [AW-1:0]   obs_am;
    logic [OBIT-1:0] obs_mv;
    logic [15:0]     obs_cnt;

    // expected errors of one burst
    int e_short, e_long, e_ovf, e_long_at;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic refresh_disp();
        if (mcount > 0) begin
            m_am = 0;
            m_mv = mstore[mhead][0];
            for (int k = 1; k < IDIM; k++)
                if (mstore[mhead][k] > m_mv) begin
                    m_mv = mstore[mhead][k];
                    m_am = k;
                end
        end
    endtask

    task automatic model_pop();
        if (mcount > 0) begin
            mhead  = (mhead + 1) % 2;
            mcount = mcount - 1;
            refresh_disp();
        end
    endtask

    task automatic model_burst(input int n, input bit ack_last);
        e_short = 0; e_long = 0; e_ovf = 0; e_long_at = -1;
        if (mcount == 2) begin
            e_ovf = 1;
        end else if (n < IDIM) begin
            e_short = 1;
        end else begin
            int slot;
            if (ack_last) model_pop();
            slot = (mhead + mcount) % 2;
            for (int k = 0; k < IDIM; k++)
                mstore[slot][k] = (stim[k] < 0) ? 0 : stim[k];
            mcount = mcount + 1;
            mcnt   = (mcnt + 1) % 65536;
            refresh_disp();
            if (n > IDIM) begin
                e_long = 1;
                e_long_at = IDIM;
            end
        end
    endtask

    task automatic model_reset();
        mhead = 0; mcount = 0; mcnt = 0; m_am = 0; m_mv = 0;
    endtask

    task automatic rand_stim(input int lo, input int hi);
        for (int k = 0; k < 64; k++) stim[k] = $urandom_range(hi - lo, 0) + lo;
    endtask

    // Drives one burst of n samples; ack_at selects the sample during which
    // frm_ack is held high (-1 for none). Records error pulses and a snapshot
    // of the presentation outputs the cycle after sample IDIM-1.
    task automatic run_burst(input int n, input int ack_at);
        obs_short = 0; obs_long = 0; obs_ovf = 0; obs_long_at = -1;
        obs_rdy = 1'b0; obs_am = '0; obs_mv = '0; obs_cnt = '0;
        for (int i = 0; i < n; i++) begin
            int s;
            s = stim[i];
            dv_in   = 1'b1;
            din     = s[OBIT-1:0];
            frm_ack = (i == ack_at);
            cyc();
            frm_ack = 1'b0;
            obs_short += int'(err_short);
            obs_ovf   += int'(err_ovf);
            if (err_long) begin
                obs_long++;
                if (obs_long_at < 0) obs_long_at = i;
            end
            if (i == IDIM - 1) begin
                obs_rdy = frm_rdy; obs_am = frm_argmax;
                obs_mv = frm_maxval; obs_cnt = frm_cnt;
            end
        end
        dv_in = 1'b0;
        for (int j = 0; j < 2; j++) begin
            cyc();
            obs_short += int'(err_short);
            obs_long  += int'(err_long);
            obs_ovf   += int'(err_ovf);
        end
    endtask

    task automatic do_ack();
        frm_ack = 1'b1;
        cyc();
        frm_ack = 1'b0;
        model_pop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        n_cmp++;
        if ({frm_rdy, frm_argmax, frm_maxval, rd_data, err_short, err_long, err_ovf, frm_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%0d am=%0d mv=%0d rd=%0d errs=%b%b%b cnt=%0d want all 0",
                     frm_rdy, frm_argmax, frm_maxval, rd_data, err_short, err_long, err_ovf, frm_cnt);
        end
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
        model_reset();
    endtask

    task automatic test_basic_frame();
        for (int k = 0; k < 64; k++) stim[k] = k * 10;
        stim[17] = 900;
        model_burst(IDIM, 1'b0);
        run_burst(IDIM, -1);
        n_cmp++;
        if ({obs_rdy, obs_am, obs_mv, obs_cnt} !== {1'b1, 6'd17, 11'd900, 16'd1}) begin
            n_bad++;
            $display("FAIL basic_last_cycle: got rdy=%0d am=%0d mv=%0d cnt=%0d want rdy=1 am=17 mv=900 cnt=1",
                     obs_rdy, obs_am, obs_mv, obs_cnt);
        end
        n_cmp++;
        if (obs_short + obs_long + obs_ovf != 0) begin
            n_bad++;
            $display("FAIL basic_errors: got %0d/%0d/%0d want 0/0/0", obs_short, obs_long, obs_ovf);
        end
        rd_addr = 6'd5; cyc();
        n_cmp++;
        if (rd_data !== 11'd50) begin
            n_bad++;
            $display("FAIL basic_rd5: got %0d want 50", rd_data);
        end
        rd_addr = 6'd50; cyc();
        n_cmp++;
        if (rd_data !== 11'd0) begin
            n_bad++;
            $display("FAIL basic_rd_oob: got %0d want 0", rd_data);
        end
        do_ack();
        n_cmp++;
        if ({frm_rdy, frm_argmax, frm_maxval} !== {1'b0, 6'd17, 11'd900}) begin
            n_bad++;
            $display("FAIL basic_after_ack: got rdy=%0d am=%0d mv=%0d want rdy=0 am=17 mv=900 (held)",
                     frm_rdy, frm_argmax, frm_maxval);
        end
    endtask

    task automatic test_tie_negative();
        rand_stim(0, 999);
        stim[3] = 1000; stim[30] = 1000; stim[8] = -5;
        model_burst(IDIM, 1'b0);
        run_burst(IDIM, -1);
        n_cmp++;
        if ({frm_rdy, frm_argmax, frm_maxval} !== {1'b1, 6'd3, 11'd1000}) begin
            n_bad++;
            $display("FAIL tie_max: got rdy=%0d am=%0d mv=%0d want rdy=1 am=3 mv=1000",
                     frm_rdy, frm_argmax, frm_maxval);
        end
        rd_addr = 6'd8; cyc();
        n_cmp++;
        if (rd_data !== 11'd0) begin
            n_bad++;
            $display("FAIL neg_clamp_rd8: got %0d want 0", rd_data);
        end
        rd_addr = 6'd30; cyc();
        n_cmp++;
        if (rd_data !== 11'd1000) begin
            n_bad++;
            $display("FAIL tie_rd30: got %0d want 1000", rd_data);
        end
        do_ack();
    endtask

    task automatic test_short_burst();
        int cnt0;
        cnt0 = mcnt;
        rand_stim(-1024, 1023);
        model_burst(20, 1'b0);
        run_burst(20, -1);
        n_cmp++;
        if (obs_short != 1 || obs_long != 0 || obs_ovf != 0 || frm_rdy !== 1'b0 || frm_cnt !== 16'(cnt0)) begin
            n_bad++;
            $display("FAIL short_burst: got short=%0d long=%0d ovf=%0d rdy=%0d cnt=%0d want 1/0/0 rdy=0 cnt=%0d",
                     obs_short, obs_long, obs_ovf, frm_rdy, frm_cnt, cnt0);
        end
        rand_stim(-1024, 1023);
        model_burst(IDIM, 1'b0);
        run_burst(IDIM, -1);
        n_cmp++;
        if ({frm_rdy, frm_argmax, frm_maxval, frm_cnt} !== {1'b1, AW'(m_am), OBIT'(m_mv), 16'(mcnt)}) begin
            n_bad++;
            $display("FAIL short_then_full: got rdy=%0d am=%0d mv=%0d cnt=%0d want rdy=1 am=%0d mv=%0d cnt=%0d",
                     frm_rdy, frm_argmax, frm_maxval, frm_cnt, m_am, m_mv, mcnt);
        end
        for (int r = 0; r < 4; r++) begin
            int a;
            a = $urandom_range(IDIM - 1, 0);
            rd_addr = AW'(a); cyc();
            n_cmp++;
            if (rd_data !== OBIT'(mstore[mhead][a])) begin
                n_bad++;
                $display("FAIL short_then_full_rd%0d: got %0d want %0d", a, rd_data, mstore[mhead][a]);
            end
        end
        do_ack();
    endtask

    task automatic test_long_burst();
        rand_stim(-1024, 1000);
        stim[42] = 1023; stim[43] = 1023; stim[44] = 1023;
        model_burst(45, 1'b0);
        run_burst(45, -1);
        n_cmp++;
        if (obs_long != 1 || obs_long_at != e_long_at || obs_short != 0 || obs_ovf != 0) begin
            n_bad++;
            $display("FAIL long_burst_err: got long=%0d at=%0d short=%0d ovf=%0d want long=1 at=%0d short=0 ovf=0",
                     obs_long, obs_long_at, obs_short, obs_ovf, e_long_at);
        end
        n_cmp++;
        if ({frm_rdy, frm_argmax, frm_maxval, frm_cnt} !== {1'b1, AW'(m_am), OBIT'(m_mv), 16'(mcnt)}) begin
            n_bad++;
            $display("FAIL long_burst_frame: got rdy=%0d am=%0d mv=%0d cnt=%0d want rdy=1 am=%0d mv=%0d cnt=%0d",
                     frm_rdy, frm_argmax, frm_maxval, frm_cnt, m_am, m_mv, mcnt);
        end
        for (int a = IDIM - 3; a < IDIM; a++) begin
            rd_addr = AW'(a); cyc();
            n_cmp++;
            if (rd_data !== OBIT'(mstore[mhead][a])) begin
                n_bad++;
                $display("FAIL long_burst_rd%0d: got %0d want %0d", a, rd_data, mstore[mhead][a]);
            end
        end
        do_ack();
    endtask

    task automatic test_overflow();
        for (int f = 0; f < 3; f++) begin
            rand_stim(-1024, 1023);
            model_burst(IDIM, 1'b0);
            run_burst(IDIM, -1);
            cyc();
        end
        n_cmp++;
        if (obs_ovf != 1 || e_ovf != 1 || obs_short != 0 || obs_long != 0 || frm_cnt !== 16'(mcnt)) begin
            n_bad++;
            $display("FAIL overflow: got ovf=%0d short=%0d long=%0d cnt=%0d want ovf=1 short=0 long=0 cnt=%0d",
                     obs_ovf, obs_short, obs_long, frm_cnt, mcnt);
        end
        for (int f = 0; f < 3; f++) begin
            n_cmp++;
            if ({frm_rdy, frm_argmax, frm_maxval} !== {mcount > 0, AW'(m_am), OBIT'(m_mv)}) begin
                n_bad++;
                $display("FAIL overflow_drain%0d: got rdy=%0d am=%0d mv=%0d want rdy=%0d am=%0d mv=%0d",
                         f, frm_rdy, frm_argmax, frm_maxval, mcount > 0, m_am, m_mv);
            end
            if (mcount > 0) begin
                rd_addr = AW'(m_am); cyc();
                n_cmp++;
                if (rd_data !== OBIT'(m_mv)) begin
                    n_bad++;
                    $display("FAIL overflow_rd%0d: got %0d want %0d", f, rd_data, m_mv);
                end
                do_ack();
            end
        end
    endtask

    task automatic test_ack_on_completion();
        rand_stim(-1024, 1023);
        model_burst(IDIM, 1'b0);
        run_burst(IDIM, -1);
        rand_stim(-1024, 1023);
        model_burst(IDIM, 1'b1);
        run_burst(IDIM, IDIM - 1);
        n_cmp++;
        if ({obs_rdy, obs_am, obs_mv, obs_cnt} !== {1'b1, AW'(m_am), OBIT'(m_mv), 16'(mcnt)}) begin
            n_bad++;
            $display("FAIL ack_on_completion: got rdy=%0d am=%0d mv=%0d cnt=%0d want rdy=1 am=%0d mv=%0d cnt=%0d",
                     obs_rdy, obs_am, obs_mv, obs_cnt, m_am, m_mv, mcnt);
        end
        do_ack();
        n_cmp++;
        if (frm_rdy !== 1'b0 || mcount != 0) begin
            n_bad++;
            $display("FAIL ack_on_completion_drain: got rdy=%0d want 0", frm_rdy);
        end
    endtask

    task automatic test_reset_mid_burst();
        int errs;
        errs = 0;
        rand_stim(-1024, 1023);
        model_burst(IDIM, 1'b0);
        run_burst(IDIM, -1);
        rand_stim(-1024, 1023);
        for (int i = 0; i < 40; i++) begin
            int s;
            s = stim[i];
            dv_in = 1'b1;
            din   = s[OBIT-1:0];
            if (i == 10) begin
                #2 rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({frm_rdy, frm_argmax, frm_maxval, rd_data, err_short, err_long, err_ovf, frm_cnt} !== '0) begin
                    n_bad++;
                    $display("FAIL reset_mid_burst: got rdy=%0d am=%0d mv=%0d rd=%0d cnt=%0d want all 0",
                             frm_rdy, frm_argmax, frm_maxval, rd_data, frm_cnt);
                end
                #1 rst_n = 1'b1;
                model_reset();
            end
            cyc();
            errs += int'(err_short) + int'(err_long) + int'(err_ovf);
        end
        dv_in = 1'b0;
        cyc(); errs += int'(err_short) + int'(err_long) + int'(err_ovf);
        cyc(); errs += int'(err_short) + int'(err_long) + int'(err_ovf);
        n_cmp++;
        if (frm_rdy !== 1'b0 || frm_cnt !== 16'd0 || errs != 0) begin
            n_bad++;
            $display("FAIL reset_burst_ignored: got rdy=%0d cnt=%0d errs=%0d want 0/0/0", frm_rdy, frm_cnt, errs);
        end
        rand_stim(-1024, 1023);
        model_burst(IDIM, 1'b0);
        run_burst(IDIM, -1);
        n_cmp++;
        if ({frm_rdy, frm_argmax, frm_maxval, frm_cnt} !== {1'b1, AW'(m_am), OBIT'(m_mv), 16'(mcnt)}) begin
            n_bad++;
            $display("FAIL reset_recover: got rdy=%0d am=%0d mv=%0d cnt=%0d want rdy=1 am=%0d mv=%0d cnt=%0d",
                     frm_rdy, frm_argmax, frm_maxval, frm_cnt, m_am, m_mv, mcnt);
        end
        do_ack();
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int n;
            n = $urandom_range(48, 20);
            if (($urandom_range(2, 0) == 0) && n < IDIM) n = IDIM;
            rand_stim(-1024, 1023);
            model_burst(n, 1'b0);
            run_burst(n, -1);
            n_cmp++;
            if (obs_short != e_short || obs_long != e_long || obs_ovf != e_ovf ||
                {frm_rdy, frm_argmax, frm_maxval, frm_cnt} !== {mcount > 0, AW'(m_am), OBIT'(m_mv), 16'(mcnt)}) begin
                n_bad++;
                $display("FAIL random_it%0d n=%0d: got errs=%0d/%0d/%0d rdy=%0d am=%0d mv=%0d cnt=%0d want errs=%0d/%0d/%0d rdy=%0d am=%0d mv=%0d cnt=%0d",
                         it, n, obs_short, obs_long, obs_ovf, frm_rdy, frm_argmax, frm_maxval, frm_cnt,
                         e_short, e_long, e_ovf, mcount > 0, m_am, m_mv, mcnt);
            end
            if (mcount > 0) begin
                int a;
                a = $urandom_range(63, 0);
                rd_addr = AW'(a); cyc();
                n_cmp++;
                if (rd_data !== ((a < IDIM) ? OBIT'(mstore[mhead][a]) : OBIT'(0))) begin
                    n_bad++;
                    $display("FAIL random_rd it%0d addr=%0d: got %0d", it, a, rd_data);
                end
            end
            if ($urandom_range(1, 0) == 1) do_ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_tie_negative();
        test_short_burst();
        test_long_burst();
        test_overflow();
        test_ack_on_completion();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
